// File: rtl/jtkicker_obj_pkg.sv
// Shared definitions for the Kicker object scheduler:
// RAM entry layout, scan FSM encoding and the queued sprite word.
package jtkicker_obj_pkg;

    localparam logic ATTR_HALF = 1'b0;
    localparam logic CODE_HALF = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD0  = 3'd1;
    localparam logic [2:0] ST_RD1  = 3'd2;
    localparam logic [2:0] ST_PUSH = 3'd3;
    localparam logic [2:0] ST_NEXT = 3'd4;

    localparam int FIFO_W = 28;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] xpos;
        logic [7:0] attr;
        logic [3:0] v;
    } obj_entry_t;

endpackage

// File: rtl/jtkicker_objsched_fifo.sv
// Small single-clock FIFO holding sprites queued for drawing.
// Push and pop act only on enabled cycles; flush empties it at once.
module jtkicker_objsched_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 28
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = cen & push & ~full & ~flush;
    assign do_pop  = cen & pop & ~empty & ~flush;
    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout    = mem[rptr[AW-1:0]];

    // Read/write pointers; flush drops every queued entry
    always_ff @(posedge clk) begin
        if (rst || (cen && flush)) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jtkicker_objsched.sv
// Per-line object table scan: keeps sprites covering the render
// line and hands them to the draw engine through a small FIFO.
module jtkicker_objsched
    import jtkicker_obj_pkg::*;
#(
    parameter int MAXOBJ     = 23,
    parameter int REV_SCAN   = 1,
    parameter int FIFO_DEPTH = 4
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen2,
    input  logic       hinit,
    input  logic [7:0] vrender,
    input  logic       flip,
    output logic [6:0] scan_addr,
    input  logic [7:0] low_dout,
    input  logic [7:0] hi_dout,
    output logic       dr_start,
    input  logic       dr_busy,
    output logic [7:0] dr_code,
    output logic [7:0] dr_xpos,
    output logic [7:0] dr_attr,
    output logic [3:0] dr_v,
    output logic       ovf,
    output logic [4:0] obj_cnt
);
    localparam logic [5:0] FIRST = (REV_SCAN != 0) ? 6'(MAXOBJ) : 6'd0;
    localparam logic [5:0] LAST  = (REV_SCAN != 0) ? 6'd0 : 6'(MAXOBJ);

    logic [2:0] st;
    logic [5:0] obj;
    logic       half;
    logic       hl;
    logic [4:0] cnt;
    logic       start_d;
    obj_entry_t cur;
    obj_entry_t head;
    logic [7:0] y;
    logic [7:0] vrf;
    logic [7:0] diff;
    logic       inzone;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       flush;

    assign scan_addr = {obj, half};

    // Sprite covers the line when the line sits 0..15 rows below its top
    assign y      = ~low_dout;
    assign vrf    = vrender ^ {8{flip}};
    assign diff   = vrf - y;
    assign inzone = diff[7:4] == 4'd0;

    assign flush = cen2 & hl & (st != ST_IDLE);
    assign push  = cen2 & ~hl & (st == ST_PUSH) & ~full;
    assign pop   = cen2 & ~empty & ~dr_busy & ~dr_start
                 & ~start_d & ~flush;

    jtkicker_objsched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen2),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (cur),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Line start latch: a one-clk hinit must survive until the next cen2
    always_ff @(posedge clk) begin
        if (rst)       hl <= 1'b0;
        else if (hinit) hl <= 1'b1;
        else if (cen2)  hl <= 1'b0;
    end

    // Table scan FSM; a new line always restarts from the first object
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= ST_IDLE;
            obj     <= 6'd0;
            half    <= ATTR_HALF;
            cnt     <= 5'd0;
            ovf     <= 1'b0;
            obj_cnt <= 5'd0;
            cur     <= '0;
        end else if (cen2) begin
            if (hl) begin
                ovf     <= st != ST_IDLE;
                obj_cnt <= cnt;
                cnt     <= 5'd0;
                obj     <= FIRST;
                half    <= ATTR_HALF;
                st      <= ST_RD0;
            end else begin
                case (st)
                    ST_RD0: begin
                        cur.attr <= low_dout;
                        cur.xpos <= hi_dout;
                        half     <= CODE_HALF;
                        st       <= ST_RD1;
                    end
                    ST_RD1: begin
                        cur.code <= hi_dout;
                        cur.v    <= diff[3:0] - 4'd1;
                        st       <= inzone ? ST_PUSH : ST_NEXT;
                    end
                    ST_PUSH: begin
                        if (!full) begin
                            if (cnt != 5'd31) cnt <= cnt + 5'd1;
                            st <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (obj == LAST) begin
                            st <= ST_IDLE;
                        end else begin
                            obj  <= (REV_SCAN != 0) ? obj - 6'd1 : obj + 6'd1;
                            half <= ATTR_HALF;
                            st   <= ST_RD0;
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

    // Draw hand-off: pop into the output registers and pulse dr_start,
    // spacing starts so dr_busy has time to rise
    always_ff @(posedge clk) begin
        if (rst) begin
            dr_start <= 1'b0;
            start_d  <= 1'b0;
            dr_code  <= 8'd0;
            dr_xpos  <= 8'd0;
            dr_attr  <= 8'd0;
            dr_v     <= 4'd0;
        end else if (cen2) begin
            dr_start <= pop;
            start_d  <= dr_start;
            if (pop) begin
                dr_code <= head.code;
                dr_xpos <= head.xpos;
                dr_attr <= head.attr;
                dr_v    <= head.v;
            end
        end
    end

endmodule

// File: tb/tb_jtkicker_objsched.sv
// Bench for jtkicker_objsched: object RAM model, draw capture and
// a line-level reference built from the table contents.
module tb_jtkicker_objsched;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] x;
        logic [7:0] attr;
        logic [3:0] v;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen2 = 1'b0;
    logic       hinit;
    logic [7:0] vrender;
    logic       flip;
    logic [6:0] scan_addr;
    logic [7:0] low_dout;
    logic [7:0] hi_dout;
    logic       dr_start;
    logic       dr_busy;
    logic [7:0] dr_code;
    logic [7:0] dr_xpos;
    logic [7:0] dr_attr;
    logic [3:0] dr_v;
    logic       ovf;
    logic [4:0] obj_cnt;

    logic [7:0] lo [128];
    logic [7:0] hi [128];
    ent_t       cap_q [$];
    ent_t       exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         since_h = 0;
    int         first_lat = -1;
    int         prev_cnt = 0;
    logic       start_q = 1'b0;

    jtkicker_objsched dut (
        .clk       (clk),
        .rst       (rst),
        .cen2      (cen2),
        .hinit     (hinit),
        .vrender   (vrender),
        .flip      (flip),
        .scan_addr (scan_addr),
        .low_dout  (low_dout),
        .hi_dout   (hi_dout),
        .dr_start  (dr_start),
        .dr_busy   (dr_busy),
        .dr_code   (dr_code),
        .dr_xpos   (dr_xpos),
        .dr_attr   (dr_attr),
        .dr_v      (dr_v),
        .ovf       (ovf),
        .obj_cnt   (obj_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cen2 = ~cen2;

    always @(posedge clk) begin
        low_dout <= lo[scan_addr];
        hi_dout  <= hi[scan_addr];
        since_h  <= hinit ? 0 : since_h + 1;
    end

    always @(negedge clk) begin
        if (dr_start && !start_q) begin
            cap_q.push_back({dr_code, dr_xpos, dr_attr, dr_v});
            if (first_lat < 0) first_lat = since_h;
        end
        start_q = dr_start;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic set_obj(input int o, input logic [7:0] y,
                           input logic [7:0] code, input logic [7:0] x,
                           input logic [7:0] attr);
        lo[2*o]   = attr;
        hi[2*o]   = x;
        lo[2*o+1] = ~y;
        hi[2*o+1] = code;
    endtask

    task automatic fill_nozone(input logic [7:0] vr, input logic fl);
        for (int o = 0; o < 24; o++)
            set_obj(o, (vr ^ {8{fl}}) + 8'h80, 8'($urandom),
                    8'($urandom), 8'($urandom));
    endtask

    task automatic fill_allzone();
        for (int o = 0; o < 24; o++)
            set_obj(o, 8'h80 - 8'(o % 16), 8'h30 + 8'(o),
                    8'h10 + 8'(o), 8'h80 | 8'(o));
    endtask

    task automatic fill_rand(input logic [7:0] vr, input logic fl);
        for (int o = 0; o < 24; o++)
            set_obj(o, (vr ^ {8{fl}}) - 8'($urandom_range(0, 40)),
                    8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Sprites drawn on a line: table order 23..0, kept when the line
    // lies 0..15 rows past the sprite top (mod 256)
    task automatic build_exp(input logic [7:0] vr, input logic fl);
        logic [7:0] yy;
        logic [7:0] d;
        exp_q.delete();
        for (int o = 23; o >= 0; o--) begin
            yy = ~lo[2*o+1];
            d  = (vr ^ {8{fl}}) - yy;
            if (d < 8'd16)
                exp_q.push_back({hi[2*o+1], hi[2*o], lo[2*o], 4'(d - 8'd1)});
        end
    endtask

    task automatic start_line(input logic [7:0] vr, input logic fl);
        vrender = vr;
        flip    = fl;
        build_exp(vr, fl);
        cap_q.delete();
        first_lat = -1;
        @(negedge clk);
        hinit = 1'b1;
        @(negedge clk);
        hinit = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_draws(input string tag);
        chk({tag, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk(tag, cap_q[i], exp_q[i]);
    endtask

    task automatic clean_line(input string tag, input logic [7:0] vr,
                              input logic fl);
        start_line(vr, fl);
        chk({tag, "_objcnt"}, obj_cnt, prev_cnt);
        chk({tag, "_ovf"}, ovf, 0);
        repeat (700) @(negedge clk);
        check_draws(tag);
        prev_cnt = exp_q.size();
    endtask

    initial begin
        rst     = 1'b1;
        hinit   = 1'b0;
        dr_busy = 1'b0;
        vrender = 8'd0;
        flip    = 1'b0;
        for (int i = 0; i < 128; i++) begin
            lo[i] = 8'd0;
            hi[i] = 8'd0;
        end
        repeat (4) @(negedge clk);
        chk("rst_start", dr_start, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_objcnt", obj_cnt, 0);
        chk("rst_addr", scan_addr, 0);
        chk("rst_code", dr_code, 0);
        chk("rst_xpos", dr_xpos, 0);
        chk("rst_attr", dr_attr, 0);
        chk("rst_v", dr_v, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single sprite in zone
        fill_nozone(8'h45, 1'b0);
        set_obj(23, 8'h40, 8'h12, 8'h80, 8'h05);
        clean_line("one", 8'h45, 1'b0);
        chk("one_ent", cap_q.size() > 0 ? cap_q[0] : '0,
            {8'h12, 8'h80, 8'h05, 4'd4});
        chk("one_lat", (first_lat >= 9 && first_lat <= 10), 1);

        // Y wrap-around
        fill_nozone(8'h02, 1'b0);
        set_obj(23, 8'hF8, 8'h21, 8'h33, 8'h44);
        clean_line("wrap", 8'h02, 1'b0);
        chk("wrap_v", cap_q.size() > 0 ? cap_q[0].v : 4'hx, 4'd9);

        // zone edges
        fill_nozone(8'h50, 1'b0);
        set_obj(23, 8'h40, 8'h01, 8'h02, 8'h03);
        clean_line("bound_hi", 8'h50, 1'b0);
        chk("bound_hi_none", cap_q.size(), 0);
        fill_nozone(8'h3F, 1'b0);
        set_obj(23, 8'h40, 8'h01, 8'h02, 8'h03);
        clean_line("bound_lo", 8'h3F, 1'b0);
        chk("bound_lo_none", cap_q.size(), 0);

        // back-pressure: fill and stall, then drain in order
        fill_allzone();
        dr_busy = 1'b1;
        start_line(8'h80, 1'b0);
        chk("bp_objcnt", obj_cnt, prev_cnt);
        repeat (200) @(negedge clk);
        chk("bp_stall_addr", scan_addr, {6'd19, 1'b1});
        repeat (20) @(negedge clk);
        chk("bp_stall_hold", scan_addr, {6'd19, 1'b1});
        chk("bp_no_start", cap_q.size(), 0);
        dr_busy = 1'b0;
        repeat (700) @(negedge clk);
        check_draws("bp_drain");
        prev_cnt = exp_q.size();

        // overflow: second hinit while the scan is stalled
        dr_busy = 1'b1;
        start_line(8'h80, 1'b0);
        chk("ovf_pre", ovf, 0);
        chk("ovf_pre_cnt", obj_cnt, prev_cnt);
        repeat (100) @(negedge clk);
        start_line(8'h80, 1'b0);
        chk("ovf_set", ovf, 1);
        chk("ovf_cnt", obj_cnt, 4);
        chk("ovf_restart", scan_addr, {6'd23, 1'b0});
        dr_busy = 1'b0;
        repeat (700) @(negedge clk);
        check_draws("ovf_flush");
        prev_cnt = exp_q.size();
        fill_rand(8'h60, 1'b0);
        clean_line("ovf_clear", 8'h60, 1'b0);

        // reset during a stalled scan
        fill_allzone();
        dr_busy = 1'b1;
        start_line(8'h80, 1'b0);
        chk("mrst_pre_cnt", obj_cnt, prev_cnt);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_start", dr_start, 0);
        chk("mrst_ovf", ovf, 0);
        chk("mrst_objcnt", obj_cnt, 0);
        chk("mrst_addr", scan_addr, 0);
        chk("mrst_out", {dr_code, dr_xpos, dr_attr, dr_v}, 0);
        rst = 1'b0;
        cap_q.delete();
        dr_busy = 1'b0;
        repeat (200) @(negedge clk);
        chk("mrst_quiet", cap_q.size(), 0);
        chk("mrst_addr_idle", scan_addr, 0);
        prev_cnt = 0;

        // random tables, lines and flip
        for (int n = 0; n < 6; n++) begin
            logic [7:0] vr;
            logic       fl;
            vr = 8'($urandom);
            fl = 1'($urandom);
            fill_rand(vr, fl);
            clean_line("rand", vr, fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
